// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle fetch/decode/execute controller (optional BZ via CTRL_BRANCH_EN)
module control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_rdata,
    input  logic       imem_ack,
    output logic [1:0] alu_op,
    output logic       imm_sel,
    output logic [1:0] imm2,
    input  logic       zero_flag,
    output logic [1:0] rf_ra1,
    output logic [1:0] rf_ra2,
    output logic [1:0] rf_wa,
    output logic       rf_we,
    output logic [7:0] pc,
    output logic       halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0] state;
    logic [7:0] ir;
    logic       z_reg;
    logic [3:0] opcode;
    logic       is_alu;
    logic       is_halt;
    logic [7:0] pc_next;

    assign opcode    = ir[7:4];
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign halted    = (state == S_HALT);

    // Instruction class from the latched opcode; unlisted opcodes fall through as NOP
    always_comb begin
        is_alu  = 1'b0;
        is_halt = 1'b0;
        case (opcode)
            4'b0000, 4'b0001, 4'b0010,
            4'b0100, 4'b0101, 4'b0110: is_alu  = 1'b1;
            4'b1111:                   is_halt = 1'b1;
            default:                   ;
        endcase
    end

`ifdef CTRL_BRANCH_EN
    // Next pc: BZ adds the sign-extended 4-bit offset when the last ALU result was zero
    always_comb begin
        pc_next = pc + 8'd1;
        if (opcode == 4'b1000 && z_reg)
            pc_next = pc + 8'd1 + {{4{ir[3]}}, ir[3:0]};
    end
`else
    // Next pc: straight-line sequencing only
    always_comb begin
        pc_next = pc + 8'd1;
    end
`endif

    // Sequencer: state, instruction register, decoded controls, write strobe, pc and zero flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= 8'd0;
            ir      <= 8'd0;
            z_reg   <= 1'b0;
            alu_op  <= 2'b00;
            imm_sel <= 1'b0;
            imm2    <= 2'b00;
            rf_ra1  <= 2'b00;
            rf_ra2  <= 2'b00;
            rf_wa   <= 2'b00;
            rf_we   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run)
                        state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_op  <= ir[5:4];
                    imm_sel <= ir[6];
                    imm2    <= ir[1:0];
                    rf_ra1  <= ir[3:2];
                    rf_wa   <= ir[3:2];
                    rf_ra2  <= ir[1:0];
                    if (is_halt)
                        state <= S_HALT;
                    else if (is_alu)
                        state <= S_EXEC;
                    else
                        state <= S_WB;
                end
                S_EXEC: begin
                    rf_we <= 1'b1;
                    state <= S_WB;
                end
                S_WB: begin
                    if (rf_we)
                        z_reg <= zero_flag;
                    rf_we <= 1'b0;
                    pc    <= pc_next;
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - randomized self-checking bench for control_fsm with instruction-level model
module tb_control_fsm;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       imem_ack;
    logic [1:0] alu_op;
    logic       imm_sel;
    logic [1:0] imm2;
    logic       zero_flag;
    logic [1:0] rf_ra1;
    logic [1:0] rf_ra2;
    logic [1:0] rf_wa;
    logic       rf_we;
    logic [7:0] pc;
    logic       halted;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mpc;
    logic       mz;
    int         zf_force = -1;

    control_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .alu_op     (alu_op),
        .imm_sel    (imm_sel),
        .imm2       (imm2),
        .zero_flag  (zero_flag),
        .rf_ra1     (rf_ra1),
        .rf_ra2     (rf_ra2),
        .rf_wa      (rf_wa),
        .rf_we      (rf_we),
        .pc         (pc),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        run        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 8'h00;
        zero_flag  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mpc   = 8'h00;
        mz    = 1'b0;
    endtask

    task automatic start();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    // Serve one instruction fetch with the given ack delay, then check execution timing and outputs
    task automatic do_instr(input logic [7:0] instr, input int delay);
        logic [3:0] op;
        logic [7:0] off;
        bit         alu;
        bit         hlt;
        bit         bz;
        int         gap;
        int         exp_gap;
        op  = instr[7:4];
        alu = (op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6});
        hlt = (op == 4'hF);
        bz  = 1'b0;
`ifdef CTRL_BRANCH_EN
        bz  = (op == 4'h8);
`endif
        check("fetch_pc", pc, mpc);
        for (int k = 0; k <= delay; k++) begin
            check("imem_req", imem_req, 1);
            check("imem_addr", imem_addr, mpc);
            imem_ack   = (k == delay);
            imem_rdata = (k == delay) ? instr : 8'($urandom);
            @(negedge clk);
        end
        imem_ack   = 1'b0;
        imem_rdata = 8'($urandom);
        gap = 0;
        while (!imem_req && !halted && gap < 10) begin
            zero_flag = (zf_force < 0) ? 1'($urandom) : 1'(zf_force);
            check("rf_we", rf_we, (alu && gap == 2) ? 1 : 0);
            if (gap >= 1) begin
                check("alu_op", alu_op, instr[5:4]);
                check("imm_sel", imm_sel, instr[6]);
                check("imm2", imm2, instr[1:0]);
                check("rf_ra1", rf_ra1, instr[3:2]);
                check("rf_wa", rf_wa, instr[3:2]);
                check("rf_ra2", rf_ra2, instr[1:0]);
            end
            if (alu && gap == 2)
                mz = zero_flag;
            @(negedge clk);
            gap++;
        end
        exp_gap = alu ? 3 : (hlt ? 1 : 2);
        check("exec_cycles", gap, exp_gap);
        if (hlt) begin
            check("halted", halted, 1);
        end else begin
            off = (bz && mz) ? {{4{instr[3]}}, instr[3:0]} : 8'h00;
            mpc = mpc + 8'd1 + off;
        end
    endtask

    initial begin
        logic [7:0] ins;
        do_reset();
        check("rst_pc", pc, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_halted", halted, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_ctrl", {alu_op, imm_sel, imm2, rf_ra1, rf_ra2, rf_wa}, 0);
        repeat (3) @(negedge clk);
        check("idle_no_req", imem_req, 0);

        start();
        do_instr(8'h06, 0);
        do_instr(8'h5B, 5);
        check("pc_after_two", pc, 2);

`ifdef CTRL_BRANCH_EN
        do_reset();
        start();
        zf_force = 1;
        do_instr(8'h14, 0);
        zf_force = -1;
        do_instr(8'h8E, 1);
        check("bz_taken_pc", pc, 0);
        do_reset();
        start();
        zf_force = 0;
        do_instr(8'h14, 0);
        zf_force = -1;
        do_instr(8'h8E, 0);
        check("bz_not_taken_pc", pc, 2);
`endif

        do_reset();
        start();
        for (int i = 0; i < 16; i++)
            do_instr(8'h30, 0);
        check("pre_reset_addr", imem_addr, 8'h10);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("fetch_wait_req", imem_req, 1);
        rst_n    = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("midfetch_rst_req", imem_req, 0);
        check("midfetch_rst_pc", pc, 0);
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle_req", imem_req, 0);
        end
        imem_ack = 1'b0;

        do_reset();
        start();
        for (int i = 0; i < 255; i++)
            do_instr(8'h30, 0);
        check("pc_ff", pc, 8'hFF);
        do_instr(8'h30, 2);
        check("pc_wrap", pc, 8'h00);

        do_reset();
        start();
        for (int i = 0; i < 300; i++) begin
            ins = 8'($urandom);
            if (ins[7:4] == 4'hF)
                ins[7:4] = 4'h3;
            do_instr(ins, $urandom_range(0, 3));
        end

        do_instr(8'hF0, 1);
        repeat (8) begin
            run      = 1'($urandom);
            imem_ack = 1'($urandom);
            @(negedge clk);
            check("halt_halted", halted, 1);
            check("halt_req", imem_req, 0);
            check("halt_rf_we", rf_we, 0);
            check("halt_pc", pc, mpc);
        end
        run      = 1'b0;
        imem_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
